pe_array: RTL
=============

# pe_array

Parametrised successor to the fixed 8-lane processing-element chain. Runs bit-parallel approximate pattern matching over LANES text characters per beat. The pattern streams one key character per beat, and the block tracks up to ERR substitution/deletion errors per lane. It sits between the key sequencer and result collector. Segments cascade through lin_in/lin_out to cover wider text windows.

## Interface
- LANES, 8, text positions (lanes) per segment
- CHAR_W, 8, character width
- ERR, 2, maximum error level; ERR+1 state bits per lane
- EL_W, $clog2(ERR+1) (min 1), err_limit width; CNT_W, $clog2(LANES+1); IDX_W, $clog2(LANES) (min 1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  key beat offered
- key_ready  out  1  beat accepted when key_valid & key_ready
- key_first  in  1  beat is pattern character 0
- key_last  in  1  beat is final pattern character
- key_char  in  CHAR_W  pattern character
- key_mask  in  1  wildcard: character matches any text
- err_limit  in  EL_W  errors allowed; sampled on key_first beat; values >ERR clamp to ERR
- text  in  LANES*CHAR_W  lane i = text[i*CHAR_W +: CHAR_W]; sampled every accepted beat
- lin_in  in  ERR+1  upstream lane-(-1) state (upstream lin_out); tie 0 for first segment
- lin_out  out  ERR+1  registered state of lane LANES-1
- busy  out  1  state == RUN
- win_valid  out  1  result valid (state == DONE)
- win_out  out  LANES  per-lane hit vector
- hit_any  out  1  |win_out
- hit_count  out  CNT_W  popcount(win_out)
- first_hit  out  IDX_W  lowest set lane index; 0 if none
- result_ack  in  1  consumer releases result

## Operation
- State R[i][e], i in 0..LANES-1, e in 0..ERR. P = previous R; on key_first beat, P = all ones for all lanes and lane -1 (lin_in ignored); otherwise P[-1] = lin_in.
- m[i] = key_mask | (text lane i == key_char).
- On accepted beat: N[i][0] = P[i-1][0] & m[i]; for e>=1, N[i][e] = (P[i-1][e] & m[i]) | P[i-1][e-1] | P[i][e-1]. R <= N.
- The N equations use registered P only. They introduce no combinational path between lanes or segments.
- On key_last beat: hit[i] = OR of N[i][e] for e <= err_limit_latched; win_out, hit_count, first_hit, hit_any load from hit.
- FSM states IDLE, RUN, DONE; key_ready = (state != DONE).
  - IDLE: beat with key_first goes to RUN, or to DONE if key_last is also set. Beat without key_first is accepted but has no effect.
  - RUN: every beat updates R. key_first restarts the pass from all-ones P and re-latches err_limit. key_last goes to DONE.
  - DONE: win_valid = 1. key_valid is ignored. result_ack goes to IDLE. win_out and the count outputs hold until the next key_last beat.
- Reset values: state IDLE, R all zero, lin_out 0, win_out 0, hit_count 0, first_hit 0, hit_any 0, win_valid 0, busy 0, key_ready 1.
- Reset deasserted mid-pass: the pass is lost. The next pass must begin with key_first.

## Timing
- Single-cycle latency: outputs of a key_last beat at edge t are visible after t; win_valid is high from t+1.
- result_ack at t while in DONE: win_valid low from t+1; key_ready high from t+1.
- result_ack outside DONE: ignored.
- Cascaded segments receive identical key beats in lockstep. lin_in at beat j equals upstream R[LANES-1] after beat j-1.

## Structure
- Shared package pe_pkg: FSM state enum (IDLE/RUN/DONE); popcount and priority-encode functions.
- One sub-module, pe_cell: a single lane holding ERR+1 state flops and the N equations. pe_array generates LANES instances and owns the FSM and result registers.

## Test plan
- LANES=8, text "ABCDABCD" (lane0='A'), lin_in=0, err_limit=0, beats 'B'(first), 'C'(last) -> win_out=8'b0100_0100, hit_count=2, first_hit=2, win_valid next cycle.
- Same text, err_limit=1, beats 'B'(first), 'D'(last) -> win_out=8'b1110_1110, hit_count=6, first_hit=1.
- Single beat with key_first&key_last, key_mask=1, err_limit=0 -> win_out=8'hFF, hit_count=8, first_hit=0.
- Two cascaded segments: upstream lane7='B', downstream lane0='C', pattern "BC" exact -> downstream win_out[0]=1, upstream win_out=0 at lane7.
- In DONE, drive key_valid beats -> outputs unchanged, key_ready=0. Then result_ack -> win_valid falls next cycle while win_out holds.
- Assert reset mid-RUN -> all outputs at reset values immediately. Then issue key_first mid-pass without reset -> result equals a fresh pass.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the approximate-match processing-element array.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

  // Widest lane vector the helper functions accept; callers zero-extend.
  localparam int MAX_LANES = 64;

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) c += int'(v[i]);
    return c;
  endfunction

  // Lowest set bit index; 0 when nothing is set.
  function automatic int prio_enc(input logic [MAX_LANES-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pe_cell.sv
// One text lane: ERR+1 error-level state flops and their next-state equations.
module pe_cell
  import pe_pkg::*;
#(
  parameter int ERR = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_first,
  input  logic         i_match,
  input  logic [ERR:0] i_left,
  output logic [ERR:0] o_state,
  output logic [ERR:0] o_next
);

  logic [ERR:0] r_state;
  logic [ERR:0] w_pl;
  logic [ERR:0] w_ps;

  // A new pass starts from an all-ones column for this lane and its left neighbour.
  always_comb begin
    w_pl   = i_first ? '1 : i_left;
    w_ps   = i_first ? '1 : r_state;
    o_next = '0;
    o_next[0] = w_pl[0] & i_match;
    for (int e = 1; e <= ERR; e++) begin
      o_next[e] = (w_pl[e] & i_match) | w_pl[e-1] | w_ps[e-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= '0;
    else if (i_en) r_state <= o_next;
  end

  assign o_state = r_state;

endmodule

// File: rtl/pe_array.sv
// LANES-wide approximate pattern matcher segment; cascades through lin_in/lin_out.
module pe_array
  import pe_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int CHAR_W = 8,
  parameter int ERR    = 2,
  // Derived widths; leave at defaults.
  parameter int EL_W   = (ERR > 0) ? $clog2(ERR + 1) : 1,
  parameter int CNT_W  = $clog2(LANES + 1),
  parameter int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_key_valid,
  output logic                    o_key_ready,
  input  logic                    i_key_first,
  input  logic                    i_key_last,
  input  logic [CHAR_W-1:0]       i_key_char,
  input  logic                    i_key_mask,
  input  logic [EL_W-1:0]         i_err_limit,
  input  logic [LANES*CHAR_W-1:0] i_text,
  input  logic [ERR:0]            i_lin_in,
  output logic [ERR:0]            o_lin_out,
  output logic                    o_busy,
  output logic                    o_win_valid,
  output logic [LANES-1:0]        o_win_out,
  output logic                    o_hit_any,
  output logic [CNT_W-1:0]        o_hit_count,
  output logic [IDX_W-1:0]        o_first_hit,
  input  logic                    i_result_ack
);

  pe_state_e        r_state, w_nstate;
  logic [EL_W-1:0]  r_el;
  logic [LANES-1:0] r_win;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_first;

  logic             w_accept;
  logic             w_upd;
  logic [EL_W-1:0]  w_el_clamp;
  logic [EL_W-1:0]  w_lim;
  logic [LANES-1:0] w_hit;
  logic [ERR:0]     w_state [LANES];
  logic [ERR:0]     w_next  [LANES];

  assign o_key_ready = (r_state != ST_DONE);
  assign w_accept    = i_key_valid & o_key_ready;
  // Beats outside a pass (IDLE without key_first) are consumed but do nothing.
  assign w_upd       = w_accept & ((r_state == ST_RUN) | i_key_first);
  assign w_el_clamp  = (int'(i_err_limit) > ERR) ? EL_W'(ERR) : i_err_limit;
  assign w_lim       = i_key_first ? w_el_clamp : r_el;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_cell #(.ERR(ERR)) u_cell (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_upd),
      .i_first (i_key_first),
      .i_match (i_key_mask | (i_text[g*CHAR_W +: CHAR_W] == i_key_char)),
      .i_left  ((g == 0) ? i_lin_in : w_state[(g == 0) ? 0 : g - 1]),
      .o_state (w_state[g]),
      .o_next  (w_next[g])
    );
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int e = 0; e <= ERR; e++) begin
        if (e <= int'(w_lim)) w_hit[i] = w_hit[i] | w_next[i][e];
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE: if (w_accept & i_key_first) w_nstate = i_key_last ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_accept & i_key_last)  w_nstate = ST_DONE;
      ST_DONE: if (i_result_ack)           w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_el    <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_first <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_upd & i_key_first) r_el <= w_el_clamp;
      // Results hold through DONE and IDLE until the next pass completes.
      if (w_upd & i_key_last) begin
        r_win   <= w_hit;
        r_cnt   <= CNT_W'(popcount(MAX_LANES'(w_hit)));
        r_first <= IDX_W'(prio_enc(MAX_LANES'(w_hit)));
      end
    end
  end

  assign o_lin_out   = w_state[LANES-1];
  assign o_busy      = (r_state == ST_RUN);
  assign o_win_valid = (r_state == ST_DONE);
  assign o_win_out   = r_win;
  assign o_hit_any   = |r_win;
  assign o_hit_count = r_cnt;
  assign o_first_hit = r_first;

endmodule
